nano_mem_arbiter: RTL and testbench
===================================

NANO_MEM_ARBITER -- requirements
Module: nano_mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_REQ, 2, number of line requesters (e.g. Icache, Dcache).
- TIMEOUT, 256, maximum WAIT_RESP cycles before forced completion.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_clk, in, 1, single clock for the whole block.
- i_rst_n, in, 1, reset; asynchronous, active-low.
- i_req_rden, in, NUM_REQ, line read request, one per requester.
- i_req_wren, in, NUM_REQ, line write-back request, one per requester.
- i_req_addr, in, NUM_REQ x 32, line address.
- i_req_wdata, in, NUM_REQ x 8 x 32, write-back line.
- o_req_gnt, out, NUM_REQ, request accepted by memory.
- o_req_rvalid, out, NUM_REQ, read response / completion pulse.
- o_req_err, out, 1, timeout flag, valid with o_req_rvalid.
- o_req_rdata, out, 8 x 32, returned line, shared by all requesters.
- o_mm_rden, out, 1, memory read.
- o_mm_wren, out, 1, memory write.
- o_mm_addr, out, 32, memory line address.
- o_mm_wdata, out, 8 x 32, memory write line.
- i_mm_gnt, in, 1, memory accepts the current command.
- i_mm_rdata, in, 8 x 32, memory read line.
- i_mm_rvalid, in, 1, memory read data valid.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE, WAIT_RESP.
REQ-004 In IDLE, requester k is eligible when i_req_rden[k] or i_req_wren[k] is 1; with any eligible requester, the block SHALL pick one round-robin, starting at rr_ptr.
- On the pick, the block SHALL latch the index, addr, wdata and op (write when wren is 1, else read), then go to ISSUE.
REQ-005 In ISSUE, the block SHALL drive o_mm_rden or o_mm_wren from the latched op, with o_mm_addr and o_mm_wdata from the latched values; all o_mm_* SHALL be held stable until i_mm_gnt.
REQ-006 o_req_gnt[k] SHALL be combinational: 1 only when state is ISSUE, the latched index is k and i_mm_gnt is 1.
REQ-007 Requesters SHALL hold their request until o_req_gnt and drop it in the next cycle.
REQ-008 On i_mm_gnt in ISSUE, rr_ptr SHALL become (index+1) mod NUM_REQ.
- For a write, the block SHALL go to IDLE and pulse o_req_rvalid[index] in the next cycle, with o_req_err = 0.
- For a read, the block SHALL go to WAIT_RESP.
REQ-009 In WAIT_RESP, on i_mm_rvalid the block SHALL register i_mm_rdata into o_req_rdata, pulse o_req_rvalid[index] for 1 cycle in the next cycle, and return to IDLE.
REQ-010 Latencies:
- Request seen in IDLE at cycle t gives o_mm_* asserted at t+1.
- A read completes 1 cycle after i_mm_rvalid.
- Back-to-back arbitration SHALL cost exactly 1 IDLE cycle.
REQ-011 A wait counter SHALL clear on entry to WAIT_RESP and increment each cycle.
- At TIMEOUT-1 with no i_mm_rvalid, the block SHALL pulse o_req_rvalid[index] with o_req_err = 1, keep o_req_rdata unchanged, and return to IDLE.
REQ-012 i_mm_rvalid in IDLE or ISSUE SHALL be ignored.
- i_mm_rvalid in the same cycle as the timeout SHALL win: normal completion, o_req_err = 0.
REQ-013 Both rden and wren from one requester SHALL be treated as a write; the read is dropped and is not re-issued.
REQ-014 At most one of o_mm_rden/o_mm_wren and at most one bit of o_req_gnt/o_req_rvalid SHALL be 1 in any cycle.
REQ-015 A requester dropping its request before o_req_gnt SHALL NOT abort the latched transaction; it completes normally.

Reset
REQ-016 Asynchronous assertion of i_rst_n = 0 SHALL immediately force:
- state IDLE, rr_ptr 0, wait counter 0;
- o_mm_rden/o_mm_wren 0, o_mm_addr 0, o_mm_wdata 0;
- o_req_rvalid 0, o_req_err 0, o_req_rdata 0.
REQ-017 Reset mid-transaction SHALL discard it with no o_req_rvalid; the first arbitration after deassertion SHALL start at requester 0.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Single read: req0 rden, addr 0x100; mm gnt at cycle 3, rvalid at cycle 6 with pattern P -> o_req_gnt[0] at 3, o_req_rvalid[0] with rdata P at 7, o_req_err 0.
- Contention: req0 and req1 both rden from reset -> req0 served first, then req1; alternation continues while both are held.
- Write-back: req1 wren, addr 0x200, wdata W -> o_mm_wren with 0x200/W stable until gnt; o_req_rvalid[1] 1 cycle after gnt; o_mm_rden never 1.
- Timeout: read with rvalid never asserted -> o_req_rvalid[0] and o_req_err 1 exactly TIMEOUT cycles after WAIT_RESP entry; next request served normally.
- Stray rvalid in IDLE -> no o_req_rvalid; rvalid on the same cycle as the timeout -> normal completion, err 0.
- Reset asserted during WAIT_RESP -> all outputs 0 immediately, no response pulse, rr_ptr 0.

Source files
------------

// File: rtl/nano_mem_arbiter.sv
// ============================================================================
// Module   : nano_mem_arbiter
// Function : round-robin arbiter that funnels cache-line requests onto one memory port
// Revision : 1.0
// ============================================================================
`default_nettype none

module nano_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_rden,
  input  logic [NUM_REQ-1:0]        i_req_wren,
  input  logic [NUM_REQ-1:0][31:0]  i_req_addr,
  input  logic [NUM_REQ-1:0][255:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_req_gnt,
  output logic [NUM_REQ-1:0]        o_req_rvalid,
  output logic                      o_req_err,
  output logic [255:0]              o_req_rdata,
  output logic                      o_mm_rden,
  output logic                      o_mm_wren,
  output logic [31:0]               o_mm_addr,
  output logic [255:0]              o_mm_wdata,
  input  logic                      i_mm_gnt,
  input  logic [255:0]              i_mm_rdata,
  input  logic                      i_mm_rvalid
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 op_wr_q, op_wr_d;
  logic [31:0]          addr_q, addr_d;
  logic [255:0]         wdata_q, wdata_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  logic                 err_q, err_d;
  logic [255:0]         rdata_q, rdata_d;

  logic [NUM_REQ-1:0]   w_eligible;
  logic                 w_pick_vld;
  logic [IDX_W-1:0]     w_pick_idx;
  logic [IDX_W-1:0]     w_cand;

  assign w_eligible = i_req_rden | i_req_wren;

  // Scan downwards so the last hit is the first eligible requester from rr_ptr.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_cand     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (w_eligible[w_cand]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wait_cnt_d = wait_cnt_q;
    rvalid_d   = '0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (w_pick_vld) begin
          idx_d   = w_pick_idx;
          op_wr_d = i_req_wren[w_pick_idx];
          addr_d  = i_req_addr[w_pick_idx];
          wdata_d = i_req_wdata[w_pick_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (i_mm_gnt) begin
          rr_ptr_d = (idx_q == c_last_idx) ? '0 : idx_q + IDX_W'(1);
          if (op_wr_q) begin
            rvalid_d[idx_q] = 1'b1;
            state_d         = IDLE;
          end else begin
            wait_cnt_d = '0;
            state_d    = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        // Real data beats the timeout when both land in the same cycle.
        if (i_mm_rvalid) begin
          rdata_d         = i_mm_rdata;
          rvalid_d[idx_q] = 1'b1;
          state_d         = IDLE;
        end else if (wait_cnt_q == c_cnt_max) begin
          rvalid_d[idx_q] = 1'b1;
          err_d           = 1'b1;
          state_d         = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      rvalid_q   <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wait_cnt_q <= wait_cnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_gnt
    assign o_req_gnt[k] = (state_q == ISSUE) && (idx_q == IDX_W'(k)) && i_mm_gnt;
  end

  assign o_mm_rden    = (state_q == ISSUE) && !op_wr_q;
  assign o_mm_wren    = (state_q == ISSUE) && op_wr_q;
  assign o_mm_addr    = addr_q;
  assign o_mm_wdata   = wdata_q;
  assign o_req_rvalid = rvalid_q;
  assign o_req_err    = err_q;
  assign o_req_rdata  = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_nano_mem_arbiter.sv
// ============================================================================
// Module   : tb_nano_mem_arbiter
// Function : scoreboard bench for nano_mem_arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nano_mem_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 32;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_rden;
  logic [NUM_REQ-1:0]        req_wren;
  logic [NUM_REQ-1:0][31:0]  req_addr;
  logic [NUM_REQ-1:0][255:0] req_wdata;
  logic [NUM_REQ-1:0]        o_req_gnt;
  logic [NUM_REQ-1:0]        o_req_rvalid;
  logic                      o_req_err;
  logic [255:0]              o_req_rdata;
  logic                      o_mm_rden;
  logic                      o_mm_wren;
  logic [31:0]               o_mm_addr;
  logic [255:0]              o_mm_wdata;
  logic                      mm_gnt;
  logic [255:0]              mm_rdata;
  logic                      mm_rvalid;

  nano_mem_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_rden   (req_rden),
    .i_req_wren   (req_wren),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_req_gnt    (o_req_gnt),
    .o_req_rvalid (o_req_rvalid),
    .o_req_err    (o_req_err),
    .o_req_rdata  (o_req_rdata),
    .o_mm_rden    (o_mm_rden),
    .o_mm_wren    (o_mm_wren),
    .o_mm_addr    (o_mm_addr),
    .o_mm_wdata   (o_mm_wdata),
    .i_mm_gnt     (mm_gnt),
    .i_mm_rdata   (mm_rdata),
    .i_mm_rvalid  (mm_rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           k;
    logic         err;
    logic [255:0] data;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [255:0] exp_rdata = '0;
  logic [1:0]   oh;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every completion pulse must match the oldest expectation.
  always @(negedge clk) begin
    check_eq("exclusive", {($countones(o_req_gnt) > 1), ($countones(o_req_rvalid) > 1),
                           (o_mm_rden & o_mm_wren)}, '0);
    if (q.size() != 0 && q[0].cyc < cyc) begin
      check_eq("rv_missing", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (o_req_rvalid != '0) begin
      if (q.size() == 0) begin
        check_eq("rv_unexpected", o_req_rvalid, '0);
      end else begin
        e  = q.pop_front();
        oh = 2'b01 << e.k;
        check_eq("rv_index", o_req_rvalid, oh);
        check_eq("rv_err", o_req_err, e.err);
        check_eq("rv_rdata", o_req_rdata, e.data);
        check_eq("rv_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < TIMEOUT + 20) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain", q.size(), 0);
  endtask

  // One requester transaction; rv_dly < 0 means memory never answers.
  task automatic run_txn(input int k, input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] data, input int gnt_dly, input int rv_dly);
    int c_gnt;
    tick();
    req_rden[k]  = rd;
    req_wren[k]  = wr;
    req_addr[k]  = addr;
    req_wdata[k] = data;
    tick();
    for (int j = 0; j < gnt_dly; j++) begin
      mm_rvalid = 1'b1;
      mm_rdata  = ~data;
      @(negedge clk);
      check_eq("issue_rden", o_mm_rden, !wr);
      check_eq("issue_wren", o_mm_wren, wr);
      check_eq("issue_addr", o_mm_addr, addr);
      if (wr) check_eq("issue_wdata", o_mm_wdata, data);
      check_eq("issue_no_gnt", o_req_gnt, '0);
      tick();
    end
    mm_rvalid = 1'b0;
    mm_gnt    = 1'b1;
    @(negedge clk);
    oh = 2'b01 << k;
    check_eq("req_gnt", o_req_gnt, oh);
    check_eq("gnt_addr", o_mm_addr, addr);
    c_gnt = cyc;
    if (wr) q.push_back('{k, 1'b0, exp_rdata, c_gnt + 1});
    tick();
    mm_gnt      = 1'b0;
    req_rden[k] = 1'b0;
    req_wren[k] = 1'b0;
    if (!wr) begin
      if (rv_dly >= 0) begin
        repeat (rv_dly) tick();
        mm_rvalid = 1'b1;
        mm_rdata  = data;
        q.push_back('{k, 1'b0, data, cyc + 1});
        exp_rdata = data;
        tick();
        mm_rvalid = 1'b0;
      end else begin
        q.push_back('{k, 1'b1, exp_rdata, cyc + TIMEOUT});
      end
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [255:0] d;
    int k;
    rst_n     = 1'b0;
    req_rden  = '0;
    req_wren  = '0;
    req_addr  = '0;
    req_wdata = '0;
    mm_gnt    = 1'b0;
    mm_rdata  = '0;
    mm_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mm_rden", o_mm_rden, 0);
    check_eq("rst_mm_wren", o_mm_wren, 0);
    check_eq("rst_mm_addr", o_mm_addr, 0);
    check_eq("rst_rvalid", o_req_rvalid, 0);
    check_eq("rst_err", o_req_err, 0);
    check_eq("rst_rdata", o_req_rdata, 0);
    tick();
    rst_n = 1'b1;

    // Contention: both readers held, strict alternation starting at requester 0.
    tick();
    req_rden    = 2'b11;
    req_addr[0] = 32'h0000_0A00;
    req_addr[1] = 32'h0000_0B00;
    for (int t = 0; t < 4; t++) begin
      k = t % 2;
      tick();
      mm_gnt = 1'b1;
      @(negedge clk);
      oh = 2'b01 << k;
      check_eq("cont_addr", o_mm_addr, (k == 0) ? 32'h0000_0A00 : 32'h0000_0B00);
      check_eq("cont_rden", o_mm_rden, 1);
      check_eq("cont_gnt", o_req_gnt, oh);
      tick();
      mm_gnt    = 1'b0;
      d         = {8{32'hC0DE_0000 + 32'(t)}};
      mm_rvalid = 1'b1;
      mm_rdata  = d;
      q.push_back('{k, 1'b0, d, cyc + 1});
      exp_rdata = d;
      if (t == 3) req_rden = '0;
      tick();
      mm_rvalid = 1'b0;
    end
    drain();

    // Single read: gnt at cycle 3, rvalid at 6, completion at 7.
    run_txn(0, 1'b1, 1'b0, 32'h0000_0100, {8{32'h1234_5678}}, 2, 2);
    // Write-back from requester 1.
    run_txn(1, 1'b0, 1'b1, 32'h0000_0200, {8{32'hDEAD_BEEF}}, 3, 0);
    // rden and wren together act as a write only.
    run_txn(0, 1'b1, 1'b1, 32'h0000_0300, {8{32'h5A5A_0300}}, 1, 0);
    repeat (5) begin
      tick();
      @(negedge clk);
      check_eq("no_reissue", o_mm_rden, 0);
    end

    // Stray rvalid while idle.
    tick();
    mm_rvalid = 1'b1;
    mm_rdata  = '1;
    tick();
    tick();
    mm_rvalid = 1'b0;
    @(negedge clk);
    check_eq("stray_rvalid", o_req_rvalid, 0);
    tick();
    @(negedge clk);
    check_eq("stray_rdata", o_req_rdata, exp_rdata);

    // Timeout, then a normal read, then rvalid on the timeout cycle.
    run_txn(0, 1'b1, 1'b0, 32'h0000_0400, {8{32'h0400_0400}}, 0, -1);
    run_txn(1, 1'b1, 1'b0, 32'h0000_0500, {8{32'h0500_0500}}, 1, 1);
    run_txn(0, 1'b1, 1'b0, 32'h0000_0600, {8{32'h0600_0600}}, 0, TIMEOUT - 1);

    // Reset while waiting for read data.
    tick();
    req_rden[0] = 1'b1;
    req_addr[0] = 32'h0000_0700;
    tick();
    mm_gnt = 1'b1;
    tick();
    mm_gnt   = 1'b0;
    req_rden = '0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_mm_rden", o_mm_rden, 0);
    check_eq("mrst_mm_wren", o_mm_wren, 0);
    check_eq("mrst_mm_addr", o_mm_addr, 0);
    check_eq("mrst_mm_wdata", o_mm_wdata, 0);
    check_eq("mrst_rvalid", o_req_rvalid, 0);
    check_eq("mrst_err", o_req_err, 0);
    check_eq("mrst_rdata", o_req_rdata, 0);
    exp_rdata = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    req_rden    = 2'b11;
    req_addr[0] = 32'h0000_0800;
    req_addr[1] = 32'h0000_0900;
    tick();
    mm_gnt = 1'b1;
    @(negedge clk);
    check_eq("post_rst_addr", o_mm_addr, 32'h0000_0800);
    check_eq("post_rst_gnt", o_req_gnt, 2'b01);
    tick();
    mm_gnt    = 1'b0;
    req_rden  = '0;
    d         = {8{32'h0800_0800}};
    mm_rvalid = 1'b1;
    mm_rdata  = d;
    q.push_back('{0, 1'b0, d, cyc + 1});
    tick();
    mm_rvalid = 1'b0;
    drain();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
